spell_wb_arbiter: RTL
=====================

// Module: spell_wb_arbiter
// PURPOSE
//  Two-master, one-slave Wishbone arbiter in front of the spell core's Wishbone slave port.
//  Master 0 is the Caravel host bus; master 1 is a local loader/debug master.
//  Grants are round-robin per bus tenure (cyc high), and each tenure is locked until cyc drops.
//  A watchdog converts a missing slave ack into a single-cycle err, so a hung core cannot stall the host.
// PARAMETERS
//  TIMEOUT   16   cycles stb may stay high without ack before err; 0 = watchdog disabled
//  AW        32   address width
//  DW        32   data width
// PORTS
//  clock          in   1    system clock (wb_clk_i domain)
//  reset          in   1    synchronous, active-high reset
//  m0_cyc/m0_stb  in   1    master 0 cycle / strobe
//  m0_we          in   1    master 0 write enable
//  m0_sel         in   4    master 0 byte select
//  m0_adr         in   AW   master 0 address
//  m0_dat_i       in   DW   master 0 write data
//  m0_ack/m0_err  out  1    master 0 ack / error
//  m0_dat_o       out  DW   master 0 read data
//  m1_*           same set as m0_*, for master 1
//  s_cyc/s_stb    out  1    to spell i_wb_cyc / i_wb_stb
//  s_we, s_sel    out  1,4  forwarded from the granted master
//  s_adr, s_dat_o out  AW,DW forwarded from the granted master
//  s_ack          in   1    from spell o_wb_ack
//  s_dat_i        in   DW   from spell o_wb_data
//  grant          out  2    one-hot current owner; 00 = idle
//  err_count      out  8    saturating count of watchdog errors
// BEHAVIOUR
//  Reset values: state IDLE, last=1 (so m0 wins the first tie), grant=00, timer=0, err_count=0.
//   All m*_ack/m*_err/s_cyc/s_stb = 0. All data/address outputs = 0.
//  FSM states: IDLE, GNT0, GNT1. All transitions are registered.
//   IDLE -> GNTx when mx_cyc=1. If both masters request, the master != last wins.
//   GNTx -> IDLE when mx_cyc=0, and last<=x.
//   There is exactly one IDLE cycle between tenures. Arbitration latency is 1 cycle from cyc to s_cyc.
//  In GNTx, the following are combinational:
//   s_cyc=mx_cyc; s_stb=mx_stb&~to_fire; s_we/s_sel/s_adr/s_dat_o come from mx.
//   mx_ack=s_ack&s_stb. mx_dat_o=s_dat_i when mx_ack=1, else 0.
//   The non-granted master sees ack=err=0 and dat_o=0; its request is held pending with no side effect.
//  In IDLE, all s_* outputs are 0. Any s_ack arriving in IDLE is ignored.
//  Watchdog:
//   timer increments each cycle with s_stb=1 and s_ack=0; it clears when s_ack=1 or s_stb=0.
//   to_fire = (TIMEOUT!=0) && (timer==TIMEOUT).
//   On to_fire: mx_err=1 for one cycle, s_stb forced to 0 that cycle, timer cleared,
//   err_count incremented, saturating at 255.
//   If s_ack and timeout coincide, ack wins: no err, no count.
//   Timer width is clog2(TIMEOUT+1).
//  After an err, the master may keep cyc high and issue a new stb; the grant is retained.
//  Reset asserted mid-tenure: at the next edge, all state and outputs return to reset values.
//   The in-flight slave transaction is abandoned (spell is reset from the same source).
//  Writes and reads are treated identically; the arbiter never buffers data.
// STRUCTURE
//  Shared package spell_bus_pkg holds:
//   arb_state_e {IDLE, GNT0, GNT1}, GRANT_NONE/GRANT_M0/GRANT_M1 constants, WB_AW/WB_DW defaults.
//  One sub-module: spell_wb_watchdog (timer, to_fire, err_count), reusable on other wrapped slaves.
//  The mux/FSM stays in spell_wb_arbiter.
// TESTING
//  1. Single master, no contention:
//     m0 reads adr 0x3000_0004, spell acks in 2 cycles with 0x0000_00AB
//     -> s_cyc rises 1 cycle after m0_cyc; m0_dat_o=0xAB with m0_ack; grant=01.
//  2. Simultaneous requests from reset:
//     m0 and m1 assert cyc together -> m0 granted first.
//     When m0_cyc drops -> 1 IDLE cycle, then grant=10.
//  3. Locked tenure:
//     m1 performs 3 back-to-back stb while holding cyc, m0 requesting throughout
//     -> all 3 go to m1; m0 waits; m0_ack stays 0.
//  4. Watchdog (TIMEOUT=16):
//     s_ack tied low, m0 stb high -> m0_err=1 exactly at cycle 16, s_stb=0 that cycle.
//     -> err_count 0->1; no m0_ack.
//  5. Ack and timeout in the same cycle (s_ack on cycle 16) -> m0_ack=1, m0_err=0, err_count unchanged.
//  6. Reset mid-tenure:
//     reset high during m1 stb -> next cycle grant=00, all acks 0.
//     After reset, on tie -> m0 wins.

Source files
------------

// File: rtl/spell_bus_pkg.sv
// Shared Wishbone arbitration types and constants for the spell bus wrapper.
package spell_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_M0   = 2'b01;
   localparam logic [1:0] GRANT_M1   = 2'b10;

   localparam int unsigned WB_AW = 32;
   localparam int unsigned WB_DW = 32;

endpackage

// File: rtl/spell_wb_watchdog.sv
// Strobe watchdog: turns a missing slave ack into a one-cycle fire pulse and
// keeps a saturating count of how often that happened.
module spell_wb_watchdog #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       stb_i,
   input  logic       ack_i,
   output logic       fire_o,
   output logic [7:0] err_count_o
);

   localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    count_q, count_d;
   logic          hit;

   always_comb begin
      hit     = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT));
      // An ack landing on the timeout cycle wins over the error.
      fire_o  = hit && stb_i && !ack_i;
      timer_d = timer_q;
      count_d = count_q;
      if (TIMEOUT == 0 || !stb_i || ack_i || fire_o) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TW'(1);
      end
      if (fire_o && count_q != 8'hFF) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         timer_q <= '0;
         count_q <= '0;
      end else begin
         timer_q <= timer_d;
         count_q <= count_d;
      end
   end

   assign err_count_o = count_q;

endmodule

// File: rtl/spell_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with tenure locking and a watchdog
// that converts a hung slave into a single-cycle err for the owning master.
module spell_wb_arbiter
   import spell_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned AW      = WB_AW,
   parameter int unsigned DW      = WB_DW
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          m0_cyc,
   input  logic          m0_stb,
   input  logic          m0_we,
   input  logic [3:0]    m0_sel,
   input  logic [AW-1:0] m0_adr,
   input  logic [DW-1:0] m0_dat_i,
   output logic          m0_ack,
   output logic          m0_err,
   output logic [DW-1:0] m0_dat_o,
   input  logic          m1_cyc,
   input  logic          m1_stb,
   input  logic          m1_we,
   input  logic [3:0]    m1_sel,
   input  logic [AW-1:0] m1_adr,
   input  logic [DW-1:0] m1_dat_i,
   output logic          m1_ack,
   output logic          m1_err,
   output logic [DW-1:0] m1_dat_o,
   output logic          s_cyc,
   output logic          s_stb,
   output logic          s_we,
   output logic [3:0]    s_sel,
   output logic [AW-1:0] s_adr,
   output logic [DW-1:0] s_dat_o,
   input  logic          s_ack,
   input  logic [DW-1:0] s_dat_i,
   output logic [1:0]    grant,
   output logic [7:0]    err_count
);

   arb_state_e state_q;
   logic       last_q;
   logic [1:0] grant_q;
   logic       gnt0, gnt1;
   logic       req_stb;
   logic       bus_ack;
   logic       wd_fire;

   // last_q holds the index of the previous owner; the other master wins a tie.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         grant_q <= GRANT_NONE;
      end else begin
         case (state_q)
            IDLE: begin
               if (m0_cyc && (!m1_cyc || last_q)) begin
                  state_q <= GNT0;
                  grant_q <= GRANT_M0;
               end else if (m1_cyc) begin
                  state_q <= GNT1;
                  grant_q <= GRANT_M1;
               end
            end
            GNT0: begin
               if (!m0_cyc) begin
                  state_q <= IDLE;
                  grant_q <= GRANT_NONE;
                  last_q  <= 1'b0;
               end
            end
            GNT1: begin
               if (!m1_cyc) begin
                  state_q <= IDLE;
                  grant_q <= GRANT_NONE;
                  last_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= GRANT_NONE;
            end
         endcase
      end
   end

   always_comb begin
      gnt0     = (state_q == GNT0);
      gnt1     = (state_q == GNT1);
      req_stb  = (gnt0 && m0_stb) || (gnt1 && m1_stb);
      s_cyc    = (gnt0 && m0_cyc) || (gnt1 && m1_cyc);
      s_stb    = req_stb && !wd_fire;
      s_we     = 1'b0;
      s_sel    = '0;
      s_adr    = '0;
      s_dat_o  = '0;
      if (gnt0) begin
         s_we    = m0_we;
         s_sel   = m0_sel;
         s_adr   = m0_adr;
         s_dat_o = m0_dat_i;
      end else if (gnt1) begin
         s_we    = m1_we;
         s_sel   = m1_sel;
         s_adr   = m1_adr;
         s_dat_o = m1_dat_i;
      end
      bus_ack  = s_ack && s_stb;
      m0_ack   = gnt0 && bus_ack;
      m1_ack   = gnt1 && bus_ack;
      m0_err   = gnt0 && wd_fire;
      m1_err   = gnt1 && wd_fire;
      m0_dat_o = m0_ack ? s_dat_i : '0;
      m1_dat_o = m1_ack ? s_dat_i : '0;
   end

   spell_wb_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clock      (clock),
      .reset      (reset),
      .stb_i      (req_stb),
      .ack_i      (s_ack),
      .fire_o     (wd_fire),
      .err_count_o(err_count)
   );

   assign grant = grant_q;

endmodule
